video_overlay: RTL

Parametrised frame-synchronous overlay stage on the RGB pixel stream. It draws N_BOX single-pixel rectangle outlines, each with its own colour, and a row of N_DIGIT seven-segment digits over the source video. All geometry and digit values are double-buffered and take effect only at a frame boundary, so there is no tearing. Sync, DE and data are pipeline-aligned at the output. It sits between the timing/ROI detection logic and the HDMI encoder.

---
 rtl/video_overlay_pkg.sv | 38 +++
 rtl/video_overlay_seg7_cell.sv | 49 ++++
 rtl/video_overlay.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/video_overlay_pkg.sv
// Shared types and constants for the video overlay: commit FSM states,
// seven-segment decode table and segment bit positions.
package video_overlay_pkg;

  // Segment bit positions in the abcdefg code (a is the MSB)
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [23:0] COLOR_BLACK = 24'h000000;
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
  localparam logic [3:0]  CODE_BLANK  = 4'd15;

  typedef enum logic {ST_IDLE, ST_PEND} commit_st_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/video_overlay_seg7_cell.sv
// Combinational hit test for one seven-segment digit cell, in local (u,v)
// coordinates that carry a sign bit from the origin subtraction.
module seg7_cell
  import video_overlay_pkg::*;
#(
  parameter int XW     = 11,
  parameter int YW     = 10,
  parameter int CELL_W = 32,
  parameter int CELL_H = 48,
  parameter int SEG_T  = 4
)(
  input  logic [XW:0] u,
  input  logic [YW:0] v,
  input  logic [3:0]  code,
  output logic        hit
);

  localparam logic [XW:0] U_W  = (XW+1)'(CELL_W);
  localparam logic [XW:0] U_T  = (XW+1)'(SEG_T);
  localparam logic [XW:0] U_R  = (XW+1)'(CELL_W - SEG_T);
  localparam logic [YW:0] V_H  = (YW+1)'(CELL_H);
  localparam logic [YW:0] V_T  = (YW+1)'(SEG_T);
  localparam logic [YW:0] V_M  = (YW+1)'(CELL_H / 2);
  localparam logic [YW:0] V_G0 = (YW+1)'(CELL_H / 2 - SEG_T / 2);
  localparam logic [YW:0] V_G1 = (YW+1)'(CELL_H / 2 + SEG_T / 2);
  localparam logic [YW:0] V_D  = (YW+1)'(CELL_H - SEG_T);

  logic [6:0] segs, lit;
  logic       in_cell, upper, left, right;

  always_comb begin
    segs    = seg_decode(code);
    // sign bit set means the pixel is left of / above the cell origin
    in_cell = !u[XW] && !v[YW] && (u < U_W) && (v < V_H);
    upper   = v < V_M;
    left    = u < U_T;
    right   = u >= U_R;
    lit        = '0;
    lit[SEG_A] = v < V_T;
    lit[SEG_B] = right && upper;
    lit[SEG_C] = right && !upper;
    lit[SEG_D] = v >= V_D;
    lit[SEG_E] = left && !upper;
    lit[SEG_F] = left && upper;
    lit[SEG_G] = (v >= V_G0) && (v < V_G1);
    hit = in_cell && |(lit & segs);
  end

endmodule

// File: rtl/video_overlay.sv
// Frame-synchronous box/digit overlay on the RGB stream, 2-cycle latency.
// Optional OVERLAY_BLINK_EN adds per-box blinking driven by a frame counter.
module video_overlay
  import video_overlay_pkg::*;
#(
  parameter int          N_BOX      = 4,
  parameter int          N_DIGIT    = 6,
  parameter int          XW         = 11,
  parameter int          YW         = 10,
  parameter int          DIG_X0     = 380,
  parameter int          DIG_Y0     = 2,
  parameter int          CELL_W     = 32,
  parameter int          CELL_H     = 48,
  parameter int          SEG_T      = 4,
  parameter int          CELL_PITCH = 40,
  parameter logic [23:0] DIG_COLOR  = COLOR_WHITE,
  parameter int          BLINK_LOG2 = 5
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [23:0]            rgb_data_src,
  input  logic                   rgb_hsync_src,
  input  logic                   rgb_vsync_src,
  input  logic                   rgb_vde_src,
  input  logic [XW-1:0]          rgb_x_src,
  input  logic [YW-1:0]          rgb_y_src,
  input  logic [N_BOX*XW-1:0]    box_left,
  input  logic [N_BOX*XW-1:0]    box_right,
  input  logic [N_BOX*YW-1:0]    box_top,
  input  logic [N_BOX*YW-1:0]    box_bottom,
  input  logic [N_BOX*24-1:0]    box_color,
  input  logic [N_BOX-1:0]       box_en,
  input  logic [N_BOX-1:0]       box_blink,
  input  logic [N_DIGIT*4-1:0]   digit_val,
  input  logic                   cfg_req,
  output logic                   cfg_ack,
  output logic [23:0]            rgb_data,
  output logic                   rgb_hsync,
  output logic                   rgb_vsync,
  output logic                   rgb_vde
);

  commit_st_e                     st;
  logic                           vs_q, frame_edge, commit;
  logic [N_BOX-1:0][XW-1:0]       left_sh, right_sh;
  logic [N_BOX-1:0][YW-1:0]       top_sh, bot_sh;
  logic [N_BOX-1:0][23:0]         color_sh;
  logic [N_BOX-1:0]               en_sh, box_vis, box_hit_c, box_hit_q;
  logic [N_DIGIT-1:0][3:0]        dig_sh;
  logic [N_DIGIT-1:0]             dig_hit_c, dig_hit_q;

  assign frame_edge = rgb_vsync_src & ~vs_q;
  // a request arriving on the boundary cycle itself commits there
  assign commit     = frame_edge & ((st == ST_PEND) | cfg_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      cfg_ack  <= 1'b0;
      vs_q     <= 1'b0;
      left_sh  <= '0;
      right_sh <= '0;
      top_sh   <= '0;
      bot_sh   <= '0;
      color_sh <= '0;
      en_sh    <= '0;
      dig_sh   <= {N_DIGIT{CODE_BLANK}};
    end else begin
      vs_q    <= rgb_vsync_src;
      cfg_ack <= commit;
      if (commit) begin
        left_sh  <= box_left;
        right_sh <= box_right;
        top_sh   <= box_top;
        bot_sh   <= box_bottom;
        color_sh <= box_color;
        en_sh    <= box_en;
        dig_sh   <= digit_val;
      end
      case (st)
        ST_IDLE: if (cfg_req && !frame_edge) st <= ST_PEND;
        ST_PEND: if (frame_edge) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef OVERLAY_BLINK_EN
  logic [BLINK_LOG2:0] blink_cnt;
  logic [N_BOX-1:0]    blink_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_sh  <= '0;
    end else begin
      if (frame_edge) blink_cnt <= blink_cnt + 1'b1;
      if (commit)     blink_sh  <= box_blink;
    end
  end

  assign box_vis = en_sh & ~(blink_sh & {N_BOX{blink_cnt[BLINK_LOG2]}});
`else
  localparam int    unused_blink_log2 = BLINK_LOG2;
  logic [N_BOX-1:0] unused_blink;
  assign unused_blink = box_blink;
  assign box_vis      = en_sh;
`endif

  for (genvar i = 0; i < N_BOX; i++) begin : g_box
    logic in_x, in_y, on_h, on_v;
    assign in_x = (rgb_x_src >= left_sh[i]) && (rgb_x_src <= right_sh[i]);
    assign in_y = (rgb_y_src >= top_sh[i])  && (rgb_y_src <= bot_sh[i]);
    assign on_h = (rgb_y_src == top_sh[i])  || (rgb_y_src == bot_sh[i]);
    assign on_v = (rgb_x_src == left_sh[i]) || (rgb_x_src == right_sh[i]);
    assign box_hit_c[i] = box_vis[i] && (left_sh[i] <= right_sh[i]) &&
                          (top_sh[i] <= bot_sh[i]) &&
                          ((on_h && in_x) || (on_v && in_y));
  end

  for (genvar k = 0; k < N_DIGIT; k++) begin : g_dig
    localparam logic [XW:0] OX = (XW+1)'(DIG_X0 + k * CELL_PITCH);
    localparam logic [YW:0] OY = (YW+1)'(DIG_Y0);
    logic [XW:0] u;
    logic [YW:0] v;
    assign u = {1'b0, rgb_x_src} - OX;
    assign v = {1'b0, rgb_y_src} - OY;
    seg7_cell #(
      .XW(XW), .YW(YW), .CELL_W(CELL_W), .CELL_H(CELL_H), .SEG_T(SEG_T)
    ) u_cell (
      .u    (u),
      .v    (v),
      .code (dig_sh[k]),
      .hit  (dig_hit_c[k])
    );
  end

  logic [23:0] s1_data, box_rgb, pix_mux;
  logic        s1_hs, s1_vs, s1_de, box_any;

  always_comb begin
    box_rgb = COLOR_BLACK;
    box_any = 1'b0;
    // walk downward so the lowest-index hit wins
    for (int i = N_BOX - 1; i >= 0; i--) begin
      if (box_hit_q[i]) begin
        box_rgb = color_sh[i];
        box_any = 1'b1;
      end
    end
    if (!s1_de)          pix_mux = COLOR_BLACK;
    else if (|dig_hit_q) pix_mux = DIG_COLOR;
    else if (box_any)    pix_mux = box_rgb;
    else                 pix_mux = s1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_hit_q <= '0;
      dig_hit_q <= '0;
      s1_data   <= '0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_de     <= 1'b0;
      rgb_data  <= '0;
      rgb_hsync <= 1'b0;
      rgb_vsync <= 1'b0;
      rgb_vde   <= 1'b0;
    end else begin
      box_hit_q <= box_hit_c;
      dig_hit_q <= dig_hit_c;
      s1_data   <= rgb_data_src;
      s1_hs     <= rgb_hsync_src;
      s1_vs     <= rgb_vsync_src;
      s1_de     <= rgb_vde_src;
      rgb_data  <= pix_mux;
      rgb_hsync <= s1_hs;
      rgb_vsync <= s1_vs;
      rgb_vde   <= s1_de;
    end
  end

endmodule
